// File: rtl/numerical_pkg.sv
// numerical_pkg: FSM state type and default sizing shared by the differentiator and integrator; CENTRAL_DIFF_EN selects history depth.
package numerical_pkg;
    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_PERIOD_LOG2 = 3;
`ifdef CENTRAL_DIFF_EN
    localparam int HIST_DEPTH = 2;
`else
    localparam int HIST_DEPTH = 1;
`endif
endpackage

// File: rtl/sample_history.sv
// sample_history: depth-DEPTH sample shift register, newest sample in the low word.
module sample_history #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   clear,
    input  logic                   load,
    input  logic [WIDTH-1:0]       data,
    output logic [DEPTH*WIDTH-1:0] taps
);
    always_ff @(posedge clk or negedge resetb)
        if (!resetb)
            taps <= '0;
        else if (clear)
            taps <= '0;
        else if (load)
            taps <= (DEPTH*WIDTH)'({taps, data});
endmodule

// File: rtl/numerical_differentiator.sv
// numerical_differentiator: saturating backward difference scaled by a shift; CENTRAL_DIFF_EN switches to x[n]-x[n-2] with one extra shift.
module numerical_differentiator
    import numerical_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int PERIOD_LOG2 = DEFAULT_PERIOD_LOG2
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic [WIDTH-1:0] signal_input,
    input  logic             sample_valid,
    input  logic             start_differentiation,
    output logic [WIDTH-1:0] derivative_result,
    output logic             result_valid,
    output logic             overflow
);
    localparam int SHIFT = PERIOD_LOG2 + HIST_DEPTH - 1;
    localparam logic [1:0] LAST = 2'(HIST_DEPTH - 1);

    state_t state, next_state;
    logic accept, emit, clear;
    logic [1:0] cnt;
    logic [HIST_DEPTH*WIDTH-1:0] taps;
    logic [WIDTH-1:0] oldest;
    logic [WIDTH:0] diff;
    logic sat;
    logic signed [WIDTH-1:0] clipped;

    sample_history #(.WIDTH(WIDTH), .DEPTH(HIST_DEPTH)) u_hist (
        .clk(clk),
        .resetb(resetb),
        .clear(clear),
        .load(accept),
        .data(signal_input),
        .taps(taps)
    );

    always_ff @(posedge clk or negedge resetb)
        if (!resetb)
            state <= IDLE;
        else
            state <= next_state;

    always_comb
        next_state = !start_differentiation ? IDLE :
                     state == IDLE ? PRIME :
                     (state == PRIME && accept && cnt == LAST) ? RUN : state;

    always_comb begin
        accept = sample_valid && start_differentiation && state != IDLE;
        emit   = accept && state == RUN;
        clear  = !start_differentiation || state == IDLE;
    end

    always_ff @(posedge clk or negedge resetb)
        if (!resetb)
            cnt <= '0;
        else if (state != PRIME)
            cnt <= '0;
        else if (accept)
            cnt <= cnt + 2'd1;

    // One guard bit exposes any difference outside the WIDTH-bit range.
    assign oldest  = taps[HIST_DEPTH*WIDTH-1 -: WIDTH];
    assign diff    = {signal_input[WIDTH-1], signal_input} - {oldest[WIDTH-1], oldest};
    assign sat     = diff[WIDTH] ^ diff[WIDTH-1];
    assign clipped = sat ? {diff[WIDTH], {(WIDTH-1){~diff[WIDTH]}}} : diff[WIDTH-1:0];

    always_ff @(posedge clk or negedge resetb)
        if (!resetb) begin
            derivative_result <= '0;
            result_valid      <= 1'b0;
            overflow          <= 1'b0;
        end else begin
            result_valid <= emit;
            if (emit)
                derivative_result <= clipped >>> SHIFT;
            if (state == IDLE && start_differentiation)
                overflow <= 1'b0;
            else if (emit && sat)
                overflow <= 1'b1;
        end
endmodule
